// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for 6502 group-one ALU instructions (imm/zp/abs).
// Fetches operand bytes over a single-outstanding read port and commits acc/N/Z/C/V.
//
// state | meaning
// IDLE  | ready for an instruction or an acc/C load
// OPLO  | reading byte at pc (imm operand, or address low byte)
// OPHI  | reading byte at pc+1 (absolute address high byte)
// DATA  | reading operand from the effective address
// EXEC  | ALU driven with acc/operand, result committed at closing edge
module alu_exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  opcode,
  input  logic [15:0] pc,
  input  logic        load,
  input  logic [7:0]  load_acc,
  input  logic        load_c,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_mode,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic [7:0]  acc,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v,
  output logic [15:0] next_pc,
  output logic        done,
  output logic        illegal
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_OPLO = 3'd1;
  localparam logic [2:0] S_OPHI = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_EXEC = 3'd4;

  localparam logic [2:0] B_ZP  = 3'b001;
  localparam logic [2:0] B_IMM = 3'b010;
  localparam logic [2:0] B_ABS = 3'b011;

  localparam logic [2:0] A_ORA = 3'b000;
  localparam logic [2:0] A_AND = 3'b001;
  localparam logic [2:0] A_EOR = 3'b010;
  localparam logic [2:0] A_ADC = 3'b011;
  localparam logic [2:0] A_CMP = 3'b110;
  localparam logic [2:0] A_SBC = 3'b111;

  localparam logic [4:0] M_ADC  = 5'd0;
  localparam logic [4:0] M_AND  = 5'd1;
  localparam logic [4:0] M_ORA  = 5'd2;
  localparam logic [4:0] M_EOR  = 5'd3;
  localparam logic [4:0] M_SBC  = 5'd4;
  localparam logic [4:0] M_PASS = 5'd31;

  logic [2:0]  state;
  logic [2:0]  aaa_q;
  logic [2:0]  bbb_q;
  logic [15:0] pc_q;
  logic [7:0]  addr_lo;
  logic [7:0]  operand;
  logic        op_legal;
  logic        rd_ack;

  always_comb begin
    op_legal = (opcode[1:0] == 2'b01)
            && ((opcode[4:2] == B_IMM) || (opcode[4:2] == B_ZP) || (opcode[4:2] == B_ABS))
            && (opcode[7:5] != 3'b100) && (opcode[7:5] != 3'b101);
  end

  assign instr_ready = (state == S_IDLE) && !load;
  // an ack with no request outstanding must never advance the sequencer
  assign rd_ack      = mem_req && mem_ack;

  always_comb begin
    alu_a        = acc;
    alu_b        = 8'h00;
    alu_mode     = M_PASS;
    alu_carry_in = 1'b0;
    if (state == S_EXEC) begin
      alu_b = operand;
      case (aaa_q)
        A_ORA:   alu_mode = M_ORA;
        A_AND:   alu_mode = M_AND;
        A_EOR:   alu_mode = M_EOR;
        A_ADC: begin
          alu_mode     = M_ADC;
          alu_carry_in = flag_c;
        end
        A_CMP: begin
          alu_mode     = M_SBC;
          alu_carry_in = 1'b1;
        end
        default: begin
          alu_mode     = M_SBC;
          alu_carry_in = flag_c;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      aaa_q    <= 3'd0;
      bbb_q    <= 3'd0;
      pc_q     <= 16'h0000;
      addr_lo  <= 8'h00;
      operand  <= 8'h00;
      acc      <= 8'h00;
      flag_n   <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= 16'h0000;
      next_pc  <= 16'h0000;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            if (op_legal) begin
              aaa_q    <= opcode[7:5];
              bbb_q    <= opcode[4:2];
              pc_q     <= pc;
              mem_req  <= 1'b1;
              mem_addr <= pc;
              state    <= S_OPLO;
            end else begin
              illegal <= 1'b1;
            end
          end else if (load) begin
            acc    <= load_acc;
            flag_c <= load_c;
          end
        end
        S_OPLO: begin
          if (rd_ack) begin
            if (bbb_q == B_IMM) begin
              operand <= mem_rdata;
              mem_req <= 1'b0;
              state   <= S_EXEC;
            end else if (bbb_q == B_ZP) begin
              mem_addr <= {8'h00, mem_rdata};
              state    <= S_DATA;
            end else begin
              addr_lo  <= mem_rdata;
              mem_addr <= pc_q + 16'd1;
              state    <= S_OPHI;
            end
          end
        end
        S_OPHI: begin
          if (rd_ack) begin
            mem_addr <= {mem_rdata, addr_lo};
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (rd_ack) begin
            operand <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (aaa_q)
            A_ADC, A_SBC: begin
              acc    <= alu_result;
              flag_c <= alu_carry;
              flag_v <= alu_overflow;
            end
            A_CMP:   flag_c <= alu_carry;
            default: acc <= alu_result;
          endcase
          flag_n  <= alu_result[7];
          flag_z  <= (alu_result == 8'h00);
          next_pc <= pc_q + ((bbb_q == B_ABS) ? 16'd2 : 16'd1);
          done    <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: stand-in ALU and memory, arithmetic reference model,
// per-cycle output comparison, directed scenarios and a randomized instruction stream.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  opcode = 8'h00;
  logic [15:0] pc = 16'h0000;
  logic        load = 1'b0;
  logic [7:0]  load_acc = 8'h00;
  logic        load_c = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  alu_a, alu_b;
  logic [4:0]  alu_mode;
  logic        alu_carry_in;
  logic [7:0]  alu_result;
  logic        alu_carry, alu_overflow;
  logic [7:0]  acc;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic [15:0] next_pc;
  logic        done, illegal;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .pc(pc), .load(load), .load_acc(load_acc), .load_c(load_c),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .acc(acc), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .next_pc(next_pc), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // stand-in for the combinational 6502 ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum      = 9'd0;
    alu_result   = alu_a;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_mode)
      5'd0: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
        alu_result   = alu_sum[7:0];
        alu_carry    = alu_sum[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_sum[7] != alu_a[7]);
      end
      5'd4: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_carry_in};
        alu_result   = alu_sum[7:0];
        alu_carry    = alu_sum[8];
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_sum[7] != alu_a[7]);
      end
      5'd1: alu_result = alu_a & alu_b;
      5'd2: alu_result = alu_a | alu_b;
      5'd3: alu_result = alu_a ^ alu_b;
      default: ;
    endcase
  end

  logic [7:0] mem [0:65535];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  bit          m_busy = 0, m_in_exec = 0;
  int          m_nreads = 0, m_rd_idx = 0;
  logic [15:0] m_addrs [0:2];
  logic [7:0]  m_acc = 8'h00, m_operand = 8'h00;
  bit          m_n = 0, m_z = 0, m_c = 0, m_v = 0;
  logic [2:0]  m_aaa = 3'd0;
  bit          m_abs = 0;
  logic [15:0] m_pc = 16'h0000, m_next_pc = 16'h0000;
  bit          exp_done = 0, exp_illegal = 0;
  int          cyc = 0, m_acc_cyc = 0, m_lat = 0, m_exp_lat = 0, waits = 0;

  function automatic int exp_mode(input logic [2:0] aaa);
    case (aaa)
      3'd0: return 2;
      3'd1: return 1;
      3'd2: return 3;
      3'd3: return 0;
      default: return 4;
    endcase
  endfunction

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  task automatic model_accept();
    logic [7:0]  op;
    logic [15:0] p1;
    op = opcode;
    if (op[1:0] != 2'b01 || op[4:2] == 3'd0 || op[4:2] > 3'd3 || op[7:5] == 3'd4 || op[7:5] == 3'd5) begin
      exp_illegal = 1;
      return;
    end
    m_busy    = 1;
    m_rd_idx  = 0;
    m_aaa     = op[7:5];
    m_pc      = pc;
    m_abs     = (op[4:2] == 3'd3);
    m_acc_cyc = cyc;
    waits     = 0;
    m_addrs[0] = pc;
    p1 = pc + 16'd1;
    if (op[4:2] == 3'd2) begin
      m_nreads  = 1;
      m_operand = mem[pc];
    end else if (op[4:2] == 3'd1) begin
      m_nreads   = 2;
      m_addrs[1] = {8'h00, mem[pc]};
      m_operand  = mem[m_addrs[1]];
    end else begin
      m_nreads   = 3;
      m_addrs[1] = p1;
      m_addrs[2] = {mem[p1], mem[pc]};
      m_operand  = mem[m_addrs[2]];
    end
  endtask

  task automatic model_commit();
    int a, b, ci, u, s;
    logic [7:0] r;
    a = m_acc; b = m_operand; ci = m_c;
    u = 0; s = 0;
    case (m_aaa)
      3'd0: u = a | b;
      3'd1: u = a & b;
      3'd2: u = a ^ b;
      3'd3: begin u = a + b + ci;       s = sgn(a) + sgn(b) + ci; end
      3'd6: u = a - b;
      default: begin u = a - b - (1 - ci); s = sgn(a) - sgn(b) - (1 - ci); end
    endcase
    r = u[7:0];
    m_n = (r >= 8'd128);
    m_z = (r == 8'd0);
    if (m_aaa == 3'd3) begin
      m_c = (u > 255); m_v = (s > 127) || (s < -128); m_acc = r;
    end else if (m_aaa == 3'd7) begin
      m_c = (u >= 0);  m_v = (s > 127) || (s < -128); m_acc = r;
    end else if (m_aaa == 3'd6) begin
      m_c = (u >= 0);
    end else begin
      m_acc = r;
    end
    m_next_pc = m_pc + (m_abs ? 16'd2 : 16'd1);
    m_lat     = cyc - m_acc_cyc + 1;
    m_exp_lat = m_nreads + waits + 2;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_in_exec = 0; exp_done = 0; exp_illegal = 0;
      m_acc = 8'h00; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    end else begin
      cyc++;
      exp_done = 0;
      exp_illegal = 0;
      if (m_busy && m_in_exec) begin
        model_commit();
        m_in_exec = 0;
        m_busy = 0;
        exp_done = 1;
      end else if (m_busy) begin
        if (mem_ack) begin
          m_rd_idx++;
          if (m_rd_idx == m_nreads) m_in_exec = 1;
        end
      end else if (instr_valid && !load) begin
        model_accept();
      end else if (load) begin
        m_acc = load_acc;
        m_c = load_c;
      end
    end
  end

  // per-cycle comparison, then the memory responds for this cycle
  int force_wait = -1;
  int req_age = 0, req_target = 0;
  int ill_cnt = 0, req_cnt = 0;
  logic [4:0]  seen_mode = 5'd31;
  logic        seen_cin = 1'b0;
  logic [15:0] ack_q [$];
  bit          exp_req;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      exp_req = m_busy && !m_in_exec;
      chk("instr_ready", instr_ready, !m_busy && !load);
      chk("done", done, exp_done);
      chk("illegal", illegal, exp_illegal);
      chk("acc", acc, m_acc);
      chk("flag_n", flag_n, m_n);
      chk("flag_z", flag_z, m_z);
      chk("flag_c", flag_c, m_c);
      chk("flag_v", flag_v, m_v);
      chk("mem_req", mem_req, exp_req);
      if (exp_req) chk("mem_addr", mem_addr, m_addrs[m_rd_idx]);
      chk("alu_a", alu_a, m_acc);
      chk("alu_b", alu_b, m_in_exec ? m_operand : 8'h00);
      chk("alu_mode", alu_mode, m_in_exec ? exp_mode(m_aaa) : 31);
      chk("alu_carry_in", alu_carry_in,
          !m_in_exec ? 1'b0 : (m_aaa == 3'd6) ? 1'b1 : (m_aaa == 3'd3 || m_aaa == 3'd7) ? m_c : 1'b0);
      if (exp_done) begin
        chk("next_pc", next_pc, m_next_pc);
        chk("latency", m_lat, m_exp_lat);
      end
      if (illegal) ill_cnt++;
      if (mem_req) req_cnt++;
      if (alu_mode != 5'd31) begin
        seen_mode = alu_mode;
        seen_cin = alu_carry_in;
      end
    end
    if (!rst_n) begin
      mem_ack = 1'b0;
      req_age = 0;
    end else if (mem_req) begin
      if (req_age == 0) req_target = (force_wait >= 0) ? force_wait : $urandom_range(0, 2);
      if (req_age == req_target) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        ack_q.push_back(mem_addr);
        req_age = 0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
        req_age++;
        waits++;
      end
    end else begin
      mem_ack = ($urandom_range(0, 7) == 0);
      mem_rdata = 8'($urandom);
      req_age = 0;
    end
  end

  task automatic do_load(input logic [7:0] a, input logic c);
    load = 1; load_acc = a; load_c = c;
    @(posedge clk); #1;
    load = 0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] p);
    int n;
    bit ok;
    n = 0; ok = 0;
    load = 0; instr_valid = 1; opcode = op; pc = p;
    while (!ok && n < 40) begin
      @(negedge clk) ok = instr_ready;
      @(posedge clk); #1;
      n++;
    end
    instr_valid = 0; opcode = 8'($urandom); pc = 16'($urandom);
    chk("accept_in_time", ok, 1'b1);
  endtask

  task automatic wait_end(input bit rnd_load);
    int n;
    n = 0;
    while (!(done || illegal) && n < 60) begin
      if (rnd_load) begin
        load = ($urandom_range(0, 1) == 1); load_acc = 8'($urandom); load_c = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    load = 0;
    chk("end_in_time", (n < 60), 1'b1);
  endtask

  task automatic chk_flags(input string tag, input logic [7:0] a, input bit n, input bit z,
                           input bit c, input bit v);
    chk({tag, "_acc"}, acc, a);
    chk({tag, "_nzcv"}, {flag_n, flag_z, flag_c, flag_v}, {n, z, c, v});
  endtask

  initial begin
    logic [7:0] ill_ops [0:2];
    int aaa_tab [0:5];
    logic [7:0] op;
    int n;
    ill_ops = '{8'hA9, 8'h89, 8'h6A};
    aaa_tab = '{0, 1, 2, 3, 6, 7};
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc", acc, 8'h00);
    chk("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 4'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_done", done, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_next_pc", next_pc, 16'h0000);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", instr_ready, 1'b1);
    @(posedge clk); #1;

    // ADC imm, zero wait
    force_wait = 0;
    mem[16'h1000] = 8'h50;
    do_load(8'h50, 1'b0);
    issue(8'h69, 16'h1000);
    wait_end(0);
    chk_flags("adc_imm", 8'hA0, 1, 0, 0, 1);
    chk("adc_imm_next_pc", next_pc, 16'h1001);
    chk("adc_imm_lat", m_lat, 3);
    chk("adc_imm_mode", seen_mode, 5'd0);

    // AND zp
    mem[16'h0200] = 8'h10;
    mem[16'h0010] = 8'hF0;
    do_load(8'h0F, 1'b1);
    ack_q.delete();
    issue(8'h25, 16'h0200);
    wait_end(0);
    chk_flags("and_zp", 8'h00, 0, 1, 1, 1);
    chk("and_zp_reads", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      chk("and_zp_rd0", ack_q[0], 16'h0200);
      chk("and_zp_rd1", ack_q[1], 16'h0010);
    end
    chk("and_zp_lat", m_lat, 4);

    // SBC abs with address wrap, two wait cycles per read
    force_wait = 2;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    mem[16'h1234] = 8'h40;
    do_load(8'h40, 1'b1);
    ack_q.delete();
    issue(8'hED, 16'hFFFF);
    wait_end(0);
    chk_flags("sbc_abs", 8'h00, 0, 1, 1, 0);
    chk("sbc_abs_next_pc", next_pc, 16'h0001);
    chk("sbc_abs_lat", m_lat, 11);
    chk("sbc_abs_reads", ack_q.size(), 3);
    if (ack_q.size() == 3) begin
      chk("sbc_abs_rd1", ack_q[1], 16'h0000);
      chk("sbc_abs_rd2", ack_q[2], 16'h1234);
    end

    // CMP imm
    force_wait = 0;
    mem[16'h0500] = 8'h40;
    do_load(8'h30, 1'b1);
    issue(8'hC9, 16'h0500);
    wait_end(0);
    chk_flags("cmp_imm", 8'h30, 1, 0, 0, 0);
    chk("cmp_imm_cin", seen_cin, 1'b1);
    chk("cmp_imm_mode", seen_mode, 5'd4);

    // illegal opcodes
    for (int i = 0; i < 3; i++) begin
      ill_cnt = 0;
      req_cnt = 0;
      issue(ill_ops[i], 16'h0600);
      wait_end(0);
      repeat (2) begin @(posedge clk); #1; end
      chk("illegal_pulses", ill_cnt, 1);
      chk("illegal_no_req", req_cnt, 0);
      chk_flags("illegal_keep", 8'h30, 1, 0, 0, 0);
    end

    // reset while the high address byte is being read
    force_wait = 5;
    issue(8'h6D, 16'h0300);
    n = 0;
    while (!(mem_req && mem_addr == 16'h0301) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_ophi", (n < 20), 1'b1);
    #2;
    rst_n = 0;
    #1;
    chk("abort_mem_req", mem_req, 1'b0);
    chk_flags("abort", 8'h00, 0, 0, 0, 0);
    chk("abort_done", done, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 1'b0);
    end
    rst_n = 1;
    force_wait = -1;
    mem[16'h0400] = 8'h05;
    issue(8'h69, 16'h0400);
    wait_end(0);
    chk_flags("after_abort", 8'h05, 0, 0, 0, 0);
    chk("after_abort_next_pc", next_pc, 16'h0401);

    // randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) do_load(8'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      else op = {3'(aaa_tab[$urandom_range(0, 5)]), 3'($urandom_range(1, 3)), 2'b01};
      issue(op, 16'($urandom));
      wait_end(1);
    end
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
